ub_affine_port_ctrl: RTL
========================

Name: ub_affine_port_ctrl

Overview:
- Iteration-domain controller that drives one unified-buffer port (write or read side) with `wen`/`ren` strobes and `ctrl_vars`.
- Walks a 3-deep affine loop nest: root, row, column. It emits one strobe per iteration at a fixed initiation interval, after a programmable schedule delay.
- Also emits the linear address and the 2x2 parity bank id, matching buffer-side bank selection (index0 % 2 + 2 * (index1 % 2)).
- One instance per buffer port, inside the compute-op wrapper.

Parameters:
- W, 16, width of each ctrl_var, addr and internal counters.
- EXT_ROOT, 1, extent of ctrl_vars[0] (outermost loop).
- EXT_ROW, 64, extent of ctrl_vars[2] (middle loop).
- EXT_COL, 64, extent of ctrl_vars[1] (innermost loop).
- ROW_STRIDE, 64, address weight of ctrl_vars[2]. The weight of ctrl_vars[1] is 1; ctrl_vars[0] carries no address weight.
- START_DELAY, 0, idle cycles between start acceptance and the first strobe (0..65535).
- II, 1, cycles between successive strobes (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort to IDLE
- start  in  1  single-cycle launch request
- stall  in  1  back-pressure; freezes the controller
- en  out  1  port strobe (wen/ren) = strobe_q & ~stall
- ctrl_vars  out  3 x W  current iteration, unpacked [2:0]: [0] root, [1] column, [2] row
- addr  out  W  ctrl_vars[1] + ctrl_vars[2]*ROW_STRIDE, truncated mod 2^W
- bank  out  2  ctrl_vars[1][0] + 2*ctrl_vars[2][0]
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after the final iteration is accepted

Behaviour:
- Reset (rst_n low, async): state IDLE; all counters 0; strobe_q, busy, done = 0; ctrl_vars = 0, addr = 0, bank = 0. Reset mid-run aborts with no done pulse.
- All state, ctrl_vars, addr and bank are registered. en is the only combinational output.
- FSM states: IDLE, DELAY, RUN, GAP.
- IDLE
  - start=1 (cycle t) → DELAY if START_DELAY>0, else RUN.
  - Loop counters are cleared to 0 and busy goes high at t+1.
- DELAY
  - Counts START_DELAY cycles, then → RUN.
  - With START_DELAY=D, strobe_q first asserts at cycle t+1+D with ctrl_vars=(0,0,0).
- RUN (strobe_q=1)
  - If stall=1: en=0 and all state holds, including delay/II counters.
  - If stall=0: the iteration is accepted (en=1). Counters advance in column→row→root order:
    - column wraps at EXT_COL-1 → 0 and increments row;
    - row wraps at EXT_ROW-1 → 0 and increments root.
  - Next state is RUN if II=1, else GAP for II-1 cycles with strobe_q=0.
- GAP: stall also freezes the GAP counter. After II-1 cycles → RUN.
- Last iteration accepted (root=EXT_ROOT-1, row=EXT_ROW-1, col=EXT_COL-1), accepted in cycle c:
  - next cycle c+1: done=1, busy=0, strobe_q=0, state IDLE;
  - ctrl_vars hold the last iteration value.
- Total strobes per run = EXT_ROOT*EXT_ROW*EXT_COL.
- start while busy is ignored. start in the same cycle as done is accepted (done pulses, new run begins).
- flush=1 (sync, any state): next cycle → IDLE, counters 0, busy=0, no done. flush has priority over start and stall.
- stall while not in RUN has no effect other than freezing the counters.
- addr arithmetic is unsigned W-bit; overflow wraps silently.

Test Plan:
- Normal run. Setup: EXT_ROOT=1, EXT_COL=4, EXT_ROW=3, ROW_STRIDE=64, II=1, START_DELAY=2; start at cycle 10.
  - Required response: en high cycles 13..24 (12 strobes).
  - First strobe: ctrl_vars=(0,0,0), addr 0, bank 0.
  - Cycle 17: ctrl_vars=(0,0,1), addr 64, bank 2.
  - Last strobe: ctrl_vars=(0,3,2), addr 131, bank 1.
  - done at cycle 25; busy high cycles 11..24.
- II=3, same extents, START_DELAY=0, start at cycle 0: en at cycles 1,4,7,...,34; done at cycle 35.
- Stall: II=1 run, stall high cycles 14-15 → en low at cycles 14-15; ctrl_vars hold (0,1,0) through cycle 16; iteration (0,1,0) accepted at cycle 16; done delayed by 2 cycles.
- flush at cycle 18 of the normal run → busy=0 at cycle 19, no done. A new start at cycle 20 restarts from (0,0,0).
- start re-asserted at cycle 15 during the normal run → ignored; strobe sequence and done cycle unchanged.
- rst_n low asynchronously mid-run (cycle 16.5) → all outputs 0 immediately; after release, en stays low until the next start.

Source files
------------

// File: rtl/ub_affine_port_ctrl.sv
// Iteration-domain controller for one unified-buffer port.
// Walks a root/row/column loop nest and issues one strobe per iteration,
// spaced II cycles apart, after START_DELAY idle cycles. It also produces the
// registered linear address and the 2x2 parity bank id of the current iteration.
module ub_affine_port_ctrl #(
   parameter int W           = 16,
   parameter int EXT_ROOT    = 1,
   parameter int EXT_ROW     = 64,
   parameter int EXT_COL     = 64,
   parameter int ROW_STRIDE  = 64,
   parameter int START_DELAY = 0,
   parameter int II          = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         start,
   input  logic         stall,
   output logic         en,
   output logic [W-1:0] ctrl_vars [2:0],
   output logic [W-1:0] addr,
   output logic [1:0]   bank,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_GAP} state_t;

   localparam logic [W-1:0]  COL_LAST  = W'(EXT_COL - 1);
   localparam logic [W-1:0]  ROW_LAST  = W'(EXT_ROW - 1);
   localparam logic [W-1:0]  ROOT_LAST = W'(EXT_ROOT - 1);
   localparam logic [W-1:0]  STRIDE    = W'(ROW_STRIDE);
   // Terminal values of the delay and gap counters; only reached when the
   // corresponding phase exists (START_DELAY > 0, II > 1).
   localparam logic [31:0]   DLY_LAST  = 32'(START_DELAY - 1);
   localparam logic [31:0]   GAP_LAST  = 32'(II - 2);

   state_t         state_q, state_d;
   logic [W-1:0]   root_q, root_d;
   logic [W-1:0]   row_q, row_d;
   logic [W-1:0]   col_q, col_d;
   logic [31:0]    dly_q, dly_d;
   logic [31:0]    gap_q, gap_d;
   logic           strobe_q, strobe_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   addr_q, addr_d;
   logic [1:0]     bank_q, bank_d;
   logic           last_iter;

   assign last_iter = (col_q == COL_LAST) && (row_q == ROW_LAST) && (root_q == ROOT_LAST);

   // Next-state logic: flush dominates, stall freezes every counter, an
   // unstalled RUN cycle accepts the current iteration.
   always_comb begin
      state_d = state_q;
      root_d  = root_q;
      row_d   = row_q;
      col_d   = col_q;
      dly_d   = dly_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
         root_d  = '0;
         row_d   = '0;
         col_d   = '0;
         dly_d   = '0;
         gap_d   = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  root_d  = '0;
                  row_d   = '0;
                  col_d   = '0;
                  dly_d   = '0;
                  gap_d   = '0;
                  busy_d  = 1'b1;
                  state_d = (START_DELAY > 0) ? S_DELAY : S_RUN;
               end
            end
            S_DELAY: begin
               if (!stall) begin
                  if (dly_q == DLY_LAST) state_d = S_RUN;
                  else                   dly_d   = dly_q + 32'd1;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  if (last_iter) begin
                     // Counters keep the final iteration visible after done.
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                           row_d  = '0;
                           root_d = root_q + 1'b1;
                        end else begin
                           row_d = row_q + 1'b1;
                        end
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                     gap_d   = '0;
                     state_d = (II > 1) ? S_GAP : S_RUN;
                  end
               end
            end
            S_GAP: begin
               if (!stall) begin
                  if (gap_q == GAP_LAST) state_d = S_RUN;
                  else                   gap_d   = gap_q + 32'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      strobe_d = (state_d == S_RUN);
      addr_d   = col_d + row_d * STRIDE;
      bank_d   = {row_d[0], col_d[0]};
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         root_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         dly_q    <= '0;
         gap_q    <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         bank_q   <= '0;
      end else begin
         state_q  <= state_d;
         root_q   <= root_d;
         row_q    <= row_d;
         col_q    <= col_d;
         dly_q    <= dly_d;
         gap_q    <= gap_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         bank_q   <= bank_d;
      end
   end

   assign en           = strobe_q & ~stall;
   assign ctrl_vars[0] = root_q;
   assign ctrl_vars[1] = col_q;
   assign ctrl_vars[2] = row_q;
   assign addr         = addr_q;
   assign bank         = bank_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
